// File: rtl/data_mem_mmio.sv
// Data-side slave: word RAM, LED register and optional compare-match timer; loads are combinational.
// Build with DMEM_TIMER_EN defined to get TCOUNT/TCMP/TCTRL (0x201-0x203) and irq; otherwise they read 0.
module data_mem_mmio #(
   parameter int RAM_AW = 9,
   parameter int LED_W  = 8,
   parameter int TMR_W  = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [9:0]       daddr,
   input  logic [31:0]      ddata_w,
   input  logic             d_w,
   input  logic             d_r,
   output logic [31:0]      ddata_r,
   output logic [LED_W-1:0] leds,
   output logic             irq
);

   localparam int RAM_WORDS = 1 << RAM_AW;

   logic [31:0]       ram [RAM_WORDS];
   logic [RAM_AW-1:0] ram_idx;
   logic              sel_ram;
   logic              sel_led;
   logic [31:0]       rd_word;

   logic [LED_W-1:0]  leds_q, leds_d;

   assign ram_idx = daddr[RAM_AW-1:0];
   assign sel_ram = ~daddr[9];
   assign sel_led = (daddr == 10'h200);

   // RAM is not reset, but a store coinciding with RST must not land.
   always_ff @(posedge CLK or posedge RST) begin
      if (!RST) begin
         if (d_w && sel_ram)
            ram[ram_idx] <= ddata_w;
      end
   end

   always_comb begin
      leds_d = leds_q;
      if (d_w && sel_led)
         leds_d = ddata_w[LED_W-1:0];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         leds_q <= '0;
      else
         leds_q <= leds_d;
   end

   assign leds = leds_q;

`ifdef DMEM_TIMER_EN
   logic [TMR_W-1:0] tcount_q, tcount_d;
   logic [TMR_W-1:0] tcmp_q, tcmp_d;
   logic             en_q, en_d;
   logic             irq_en_q, irq_en_d;
   logic             flag_q, flag_d;
   logic             irq_q, irq_d;
   logic             match;
   logic             sel_tcount, sel_tcmp, sel_tctrl;

   assign sel_tcount = (daddr == 10'h201);
   assign sel_tcmp   = (daddr == 10'h202);
   assign sel_tctrl  = (daddr == 10'h203);
   assign match      = en_q && (tcount_q == tcmp_q);

   // Later assignments carry priority: CPU store over count, match over write-1-clear.
   always_comb begin
      tcount_d = tcount_q;
      tcmp_d   = tcmp_q;
      en_d     = en_q;
      irq_en_d = irq_en_q;
      flag_d   = flag_q;
      if (en_q)
         tcount_d = match ? '0 : tcount_q + 1'b1;
      if (d_w && sel_tcount)
         tcount_d = ddata_w[TMR_W-1:0];
      if (d_w && sel_tcmp)
         tcmp_d = ddata_w[TMR_W-1:0];
      if (d_w && sel_tctrl) begin
         en_d     = ddata_w[0];
         irq_en_d = ddata_w[1];
         if (ddata_w[2])
            flag_d = 1'b0;
      end
      if (match)
         flag_d = 1'b1;
      irq_d = flag_q & irq_en_q;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tcount_q <= '0;
         tcmp_q   <= '1;
         en_q     <= 1'b0;
         irq_en_q <= 1'b0;
         flag_q   <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         tcount_q <= tcount_d;
         tcmp_q   <= tcmp_d;
         en_q     <= en_d;
         irq_en_q <= irq_en_d;
         flag_q   <= flag_d;
         irq_q    <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      rd_word = '0;
      if (sel_ram) begin
         rd_word = ram[ram_idx];
      end else begin
         case (daddr[8:0])
            9'h000:  rd_word = 32'(leds_q);
`ifdef DMEM_TIMER_EN
            9'h001:  rd_word = 32'(tcount_q);
            9'h002:  rd_word = 32'(tcmp_q);
            9'h003:  rd_word = {29'd0, flag_q, irq_en_q, en_q};
`endif
            default: rd_word = '0;
         endcase
      end
      ddata_r = d_r ? rd_word : '0;
   end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Randomised bench for data_mem_mmio against a behavioural memory-map model.
module tb_data_mem_mmio;
   localparam int RAM_AW = 9;
   localparam int LED_W  = 8;
   localparam int TMR_W  = 32;
   localparam logic [31:0] TMASK = 32'((64'd1 << TMR_W) - 64'd1);
   localparam logic [31:0] LMASK = 32'((64'd1 << LED_W) - 64'd1);
`ifdef DMEM_TIMER_EN
   localparam bit TIMER = 1'b1;
`else
   localparam bit TIMER = 1'b0;
`endif

   logic             CLK = 1'b0;
   logic             RST;
   logic [9:0]       daddr;
   logic [31:0]      ddata_w;
   logic             d_w;
   logic             d_r;
   logic [31:0]      ddata_r;
   logic [LED_W-1:0] leds;
   logic             irq;

   int n_checks = 0;
   int n_errors = 0;

   data_mem_mmio #(.RAM_AW(RAM_AW), .LED_W(LED_W), .TMR_W(TMR_W)) dut (
      .CLK(CLK), .RST(RST), .daddr(daddr), .ddata_w(ddata_w), .d_w(d_w), .d_r(d_r),
      .ddata_r(ddata_r), .leds(leds), .irq(irq)
   );

   always #5 CLK = ~CLK;

   logic [31:0] m_ram [512];
   bit          m_vld [512];
   logic [31:0] m_leds, m_tcount, m_tcmp;
   bit          m_en, m_irq_en, m_flag, m_irq;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_leds = 0; m_tcount = 0; m_tcmp = TMASK;
      m_en = 0; m_irq_en = 0; m_flag = 0; m_irq = 0;
   endtask

   function automatic int m_idx(input logic [9:0] a);
      return int'(a) % (1 << RAM_AW);
   endfunction

   function automatic bit m_known(input logic [9:0] a);
      if (a < 10'h200) return m_vld[m_idx(a)];
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_read(input logic [9:0] a);
      if (a < 10'h200) return m_ram[m_idx(a)];
      case (a)
         10'h200: return m_leds;
         10'h201: return TIMER ? m_tcount : 32'd0;
         10'h202: return TIMER ? m_tcmp : 32'd0;
         10'h203: return TIMER ? {29'd0, m_flag, m_irq_en, m_en} : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // One clock edge of the memory map, from the register descriptions.
   task automatic m_step(input logic [9:0] a, input logic [31:0] wd, input bit w);
      bit          hit, nflag;
      logic [31:0] ncount;
      if (w && a < 10'h200) begin
         m_ram[m_idx(a)] = wd;
         m_vld[m_idx(a)] = 1'b1;
      end
      if (w && a == 10'h200) m_leds = wd & LMASK;
      if (TIMER) begin
         hit    = m_en && (m_tcount == m_tcmp);
         ncount = !m_en ? m_tcount : (hit ? 32'd0 : ((m_tcount + 32'd1) & TMASK));
         nflag  = m_flag;
         m_irq  = m_flag && m_irq_en;
         if (w && a == 10'h201) ncount = wd & TMASK;
         if (w && a == 10'h202) m_tcmp = wd & TMASK;
         if (w && a == 10'h203) begin
            m_en = wd[0]; m_irq_en = wd[1];
            if (wd[2]) nflag = 1'b0;
         end
         if (hit) nflag = 1'b1;
         m_flag   = nflag;
         m_tcount = ncount;
      end
   endtask

   task automatic cycle(input logic [9:0] a, input logic [31:0] wd, input bit w, input bit r,
                        output logic [31:0] got, output logic got_irq);
      @(negedge CLK);
      daddr = a; ddata_w = wd; d_w = w; d_r = r;
      #1;
      got = ddata_r; got_irq = irq;
      if (r) begin
         if (m_known(a)) check("rd", ddata_r, m_read(a));
      end else begin
         check("rd_idle", ddata_r, 32'd0);
      end
      check("leds", 32'(leds), m_leds);
      check("irq", {31'd0, irq}, {31'd0, m_irq});
      @(posedge CLK);
      m_step(a, wd, w);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got, saved, wd;
      logic        gi;
      logic [9:0]  a;
      bit          w, r;
      int          sel;
      int          exp_seq [5] = '{0, 1, 2, 3, 0};

      RST = 1'b1; daddr = '0; ddata_w = '0; d_w = 1'b0; d_r = 1'b0;
      m_reset();
      #12;
      check("rst_leds", 32'(leds), 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_rd_idle", ddata_r, 32'd0);
      daddr = 10'h202; d_r = 1'b1; #1;
      check("rst_tcmp", ddata_r, TIMER ? TMASK : 32'd0);
      d_r = 1'b0;
      @(negedge CLK); RST = 1'b0;

      for (int i = 0; i < 16; i++) cycle(10'(i), $urandom, 1, 0, got, gi);
      cycle(10'h1FF, $urandom, 1, 0, got, gi);

      cycle(10'h005, 32'hDEADBEEF, 1, 0, got, gi);
      cycle(10'h005, 32'h0, 0, 1, got, gi);
      check("ld_deadbeef", got, 32'hDEADBEEF);
      cycle(10'h005, 32'h12345678, 1, 1, got, gi);
      check("rw_prewrite", got, 32'hDEADBEEF);
      cycle(10'h005, 32'h0, 0, 1, got, gi);
      check("rw_postwrite", got, 32'h12345678);
      cycle(10'h200, 32'h1A5, 1, 0, got, gi);
      #1;
      check("leds_a5", 32'(leds), 32'h0000_00A5);
      cycle(10'h300, 32'h0, 0, 1, got, gi);
      check("mmio_hole", got, 32'd0);
      cycle(10'h200, 32'h0, 0, 0, got, gi);
      check("rd_off", got, 32'd0);

`ifdef DMEM_TIMER_EN
      cycle(10'h202, 32'd3, 1, 0, got, gi);
      cycle(10'h201, 32'd0, 1, 0, got, gi);
      cycle(10'h203, 32'd3, 1, 0, got, gi);
      for (int k = 0; k < 5; k++) begin
         cycle(10'h201, 32'd0, 0, 1, got, gi);
         check("tcount_seq", got, 32'(exp_seq[k]));
      end
      check("irq_lag", {31'd0, gi}, 32'd0);
      cycle(10'h203, 32'd0, 0, 1, got, gi);
      check("tctrl_flag", got, 32'd7);
      check("irq_rise", {31'd0, gi}, 32'd1);
      cycle(10'h203, 32'd7, 1, 0, got, gi);
      cycle(10'h203, 32'd7, 1, 1, got, gi);
      check("w1c_clear", got, 32'd3);
      cycle(10'h203, 32'd0, 0, 1, got, gi);
      check("w1c_vs_match", got, 32'd7);
      cycle(10'h201, 32'd10, 1, 0, got, gi);
      cycle(10'h201, 32'd0, 0, 1, got, gi);
      check("tcount_store", got, 32'd10);
      cycle(10'h201, 32'd0, 0, 1, got, gi);
      check("tcount_resume", got, 32'd11);
      cycle(10'h202, 32'd0, 1, 0, got, gi);
      cycle(10'h201, 32'd0, 1, 0, got, gi);
      for (int k = 0; k < 2; k++) begin
         cycle(10'h201, 32'd0, 0, 1, got, gi);
         check("tcmp0_hold", got, 32'd0);
      end
`else
      for (int k = 1; k < 4; k++) begin
         cycle(10'(10'h200 + k), 32'hFFFF_FFFF, 1, 0, got, gi);
         cycle(10'(10'h200 + k), 32'h0, 0, 1, got, gi);
         check("no_timer_rd", got, 32'd0);
      end
`endif

      for (int n = 0; n < 3000; n++) begin
         sel = $urandom_range(0, 9);
         w = ($urandom_range(0, 1) == 1);
         r = ($urandom_range(0, 3) != 0);
         wd = $urandom;
         if (sel < 5) begin
            a = ($urandom_range(0, 16) == 16) ? 10'h1FF : 10'($urandom_range(0, 15));
         end else if (sel < 9) begin
            a = 10'(10'h200 + sel - 5);
            if (sel >= 6) begin
               w  = ($urandom_range(0, 3) == 0);
               wd = 32'($urandom_range(0, (sel == 8) ? 7 : 6));
            end
         end else begin
            a = 10'($urandom_range(10'h204, 10'h3FF));
         end
         cycle(a, wd, w, r, got, gi);
      end

      cycle(10'h202, 32'd5, 1, 0, got, gi);
      cycle(10'h203, 32'd3, 1, 0, got, gi);
      cycle(10'h200, 32'h3C, 1, 0, got, gi);
      cycle(10'h201, 32'd0, 0, 0, got, gi);
      saved = m_ram[7];
      @(negedge CLK);
      daddr = 10'h007; ddata_w = ~saved; d_w = 1'b1; d_r = 1'b0;
      #1 RST = 1'b1;
      #1;
      check("rst_mid_leds", 32'(leds), 32'd0);
      check("rst_mid_irq", {31'd0, irq}, 32'd0);
      check("rst_mid_idle", ddata_r, 32'd0);
      d_r = 1'b1;
      daddr = 10'h201; #1; check("rst_mid_tcount", ddata_r, 32'd0);
      daddr = 10'h202; #1; check("rst_mid_tcmp", ddata_r, TIMER ? TMASK : 32'd0);
      daddr = 10'h203; #1; check("rst_mid_tctrl", ddata_r, 32'd0);
      daddr = 10'h007; d_r = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0; d_w = 1'b0;
      m_reset();
      cycle(10'h007, 32'd0, 0, 1, got, gi);
      check("rst_abort_store", got, saved);
      cycle(10'h201, 32'd0, 0, 1, got, gi);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
